// File: rtl/pc_fetch_seq.sv
// F-stage fetch sequencer: owns the fetch PC, one im request in flight, 2-entry prefetch queue, delay-slot redirects.
// Latency: a word returned (im_req && im_ready) in cycle n is at the queue head (f_valid) in cycle n+1.
// Backpressure: stall holds the head; fetching continues until queued + in-flight = 2. Option: PC_FETCH_SEQ_ALIGN_CHECK_EN.
module pc_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic [31:0] im_rdata,
    output logic        f_valid,
    output logic [31:0] f_pc,
    output logic [31:0] f_pc8,
    output logic [31:0] f_instr,
    output logic        f_adel
);

    logic [31:0] pc_q, addr_q, tgt_q;
    logic        tgt_vld, outst, drop, en_q, halt_q;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        q_adel  [2];
    logic [1:0]  cnt;

    logic [31:0] n_pc    [2];
    logic [31:0] n_instr [2];
    logic        n_adel  [2];
    logic [1:0]  n_cnt;
    logic [31:0] n_pcq, n_tgt;
    logic        n_tgt_vld, n_drop, n_halt;

    logic [1:0]  occ;
    logic        can_issue, misal, new_req, adel_push, done, pop, redir, push_vld;
    logic [31:0] push_pc, push_instr;

    assign occ       = cnt + {1'b0, outst};
    assign can_issue = en_q && !halt_q && !outst && (occ < 2'd2);
`ifdef PC_FETCH_SEQ_ALIGN_CHECK_EN
    assign misal     = (pc_q[1:0] != 2'b00);
`else
    assign misal     = 1'b0;
`endif
    assign new_req   = can_issue && !misal;
    assign adel_push = can_issue && misal;

    // Request lines come from state only; addr_q holds the address once pc_q has moved on.
    assign im_req    = outst || new_req;
    assign im_addr   = outst ? addr_q : pc_q;

    assign done      = im_req && im_ready;
    assign f_valid   = (cnt != 2'd0);
    assign pop       = f_valid && !stall;
    assign redir     = redirect && !stall;

    assign push_vld   = (done && !drop) || adel_push;
    assign push_pc    = adel_push ? pc_q : im_addr;
    assign push_instr = adel_push ? 32'h0 : im_rdata;

    assign f_pc    = q_pc[0];
    assign f_pc8   = q_pc[0] + 32'd8;
    assign f_instr = q_instr[0];
    assign f_adel  = q_adel[0];

    always_comb begin
        n_pc      = q_pc;
        n_instr   = q_instr;
        n_adel    = q_adel;
        n_cnt     = cnt;
        n_pcq     = pc_q;
        n_tgt     = tgt_q;
        n_tgt_vld = tgt_vld;
        n_drop    = drop && !done;
        n_halt    = halt_q || (adel_push && !tgt_vld);

        if (pop) begin
            n_pc[0]    = q_pc[1];
            n_instr[0] = q_instr[1];
            n_adel[0]  = q_adel[1];
            n_cnt      = cnt - 2'd1;
        end
        if (push_vld) begin
            if (n_cnt == 2'd0) begin
                n_pc[0]    = push_pc;
                n_instr[0] = push_instr;
                n_adel[0]  = adel_push;
            end else begin
                n_pc[1]    = push_pc;
                n_instr[1] = push_instr;
                n_adel[1]  = adel_push;
            end
            n_cnt = n_cnt + 2'd1;
        end

        // The issuing slot consumes a pending target instead of falling through.
        if (new_req || adel_push) begin
            if (tgt_vld) begin
                n_pcq     = tgt_q;
                n_tgt_vld = 1'b0;
            end else if (new_req) begin
                n_pcq = pc_q + 32'd4;
            end
        end

        if (redir) begin
            n_tgt_vld = 1'b0;
            n_halt    = 1'b0;
            if (cnt != 2'd0) begin
                // Head is the delay slot and leaves now; everything behind it is squashed.
                n_cnt = 2'd0;
                n_pcq = redirect_pc;
                if (im_req && !im_ready)
                    n_drop = 1'b1;
            end else if (im_req || adel_push) begin
                // The word in flight (or issuing now) is the delay slot; pc_q is already past it.
                n_pcq = redirect_pc;
            end else begin
                n_tgt     = redirect_pc;
                n_tgt_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            tgt_q      <= 32'h0;
            tgt_vld    <= 1'b0;
            outst      <= 1'b0;
            drop       <= 1'b0;
            en_q       <= 1'b0;
            halt_q     <= 1'b0;
            cnt        <= 2'd0;
            q_pc[0]    <= 32'h0;
            q_pc[1]    <= 32'h0;
            q_instr[0] <= 32'h0;
            q_instr[1] <= 32'h0;
            q_adel[0]  <= 1'b0;
            q_adel[1]  <= 1'b0;
        end else begin
            en_q    <= 1'b1;
            pc_q    <= n_pcq;
            tgt_q   <= n_tgt;
            tgt_vld <= n_tgt_vld;
            drop    <= n_drop;
            halt_q  <= n_halt;
            cnt     <= n_cnt;
            q_pc    <= n_pc;
            q_instr <= n_instr;
            q_adel  <= n_adel;
            if (new_req && !im_ready) begin
                outst  <= 1'b1;
                addr_q <= pc_q;
            end else if (done) begin
                outst <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed scenarios plus randomized stall/redirect/wait-state traffic against a program-order model.
module tb_pc_fetch_seq;

    logic        clk = 1'b0;
    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic        im_req, im_ready;
    logic [31:0] im_addr, im_rdata;
    logic        f_valid, f_adel;
    logic [31:0] f_pc, f_pc8, f_instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_seq dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
        .f_valid(f_valid), .f_pc(f_pc), .f_pc8(f_pc8), .f_instr(f_instr), .f_adel(f_adel)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Memory: wait states per request, fixed or random; data is a function of the address.
    logic mem_ready = 1'b0, force_ready = 1'b0, busy = 1'b0, mem_rand = 1'b0;
    int   wcnt = 0, mem_wait = 0;
    assign im_ready = mem_ready | force_ready;
    assign im_rdata = im_ready ? word(im_addr) : 32'hBAD0_BAD0;

    always begin
        @(posedge clk);
        #2;
        if (reset) begin
            busy      = 1'b0;
            mem_ready = 1'b0;
        end else begin
            if (mem_ready) busy = 1'b0;
            mem_ready = 1'b0;
            if (im_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
                end
                if (wcnt == 0) mem_ready = 1'b1;
                else wcnt--;
            end
        end
    end

    // Program-order model: next PC D should see, plus a redirect target waiting behind its delay slot.
    logic [31:0] exp_pc = 32'h0000_3000, tgt_pc = 32'h0;
    logic        pend = 1'b0, wait_tgt = 1'b0;
    int          pops = 0;
    logic        prev_hold = 1'b0, prev_wait = 1'b0;
    logic [31:0] prev_pc = 32'h0, prev_instr = 32'h0, prev_addr = 32'h0;

    always @(negedge clk) begin
        if (reset) begin
            exp_pc    = 32'h0000_3000;
            pend      = 1'b0;
            wait_tgt  = 1'b0;
            prev_hold = 1'b0;
            prev_wait = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(f_valid), 32'd1);
                chk("hold_pc", f_pc, prev_pc);
                chk("hold_instr", f_instr, prev_instr);
            end
            if (prev_wait) begin
                chk("req_kept", 32'(im_req), 32'd1);
                chk("addr_stable", im_addr, prev_addr);
            end
            if (f_valid && !stall) begin
                logic exp_adel;
`ifdef PC_FETCH_SEQ_ALIGN_CHECK_EN
                exp_adel = (exp_pc[1:0] != 2'b00);
`else
                exp_adel = 1'b0;
`endif
                chk("pop_pc", f_pc, exp_pc);
                chk("pop_pc8", f_pc8, exp_pc + 32'd8);
                chk("pop_instr", f_instr, exp_adel ? 32'h0 : word(exp_pc));
                chk("pop_adel", 32'(f_adel), 32'(exp_adel));
                pops++;
                if (pend) begin
                    exp_pc = tgt_pc;
                    pend   = 1'b0;
                end else begin
                    wait_tgt = 1'b0;
                    exp_pc   = exp_pc + 32'd4;
                end
            end
            if (redirect && !stall) begin
                wait_tgt = 1'b1;
                if (f_valid) exp_pc = redirect_pc;
                else begin
                    pend   = 1'b1;
                    tgt_pc = redirect_pc;
                end
            end
            prev_hold  = f_valid && stall;
            prev_pc    = f_pc;
            prev_instr = f_instr;
            prev_wait  = im_req && !im_ready;
            prev_addr  = im_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_head(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 80; i++) begin
            if (f_valid && f_pc === pc) break;
            step();
        end
        chk(tag, f_valid ? f_pc : 32'h0000_0001, pc);
    endtask

    task automatic pop_next(input string tag, input logic [31:0] pc);
        for (int i = 0; i < 80; i++) begin
            if (f_valid) break;
            step();
        end
        chk(tag, f_valid ? f_pc : 32'h0000_0001, pc);
        step();
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 80; i++) begin
            if (f_valid) break;
            step();
        end
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        step();
        redirect = 1'b0;
    endtask

    initial begin
        int start;
        logic [31:0] r;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        step();
        do_reset();

        // Reset values, then one instruction per cycle with zero-wait memory.
        chk("rst_im_req", 32'(im_req), 32'd0);
        chk("rst_im_addr", im_addr, 32'h0000_3000);
        chk("rst_f_valid", 32'(f_valid), 32'd0);
        chk("rst_f_pc", f_pc, 32'h0);
        chk("rst_f_pc8", f_pc8, 32'h8);
        chk("rst_f_instr", f_instr, 32'h0);
        chk("rst_f_adel", 32'(f_adel), 32'd0);
        step();
        chk("first_req", 32'(im_req), 32'd1);
        chk("first_addr", im_addr, 32'h0000_3000);
        chk("first_nvalid", 32'(f_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stream_valid", 32'(f_valid), 32'd1);
            chk("stream_pc", f_pc, 32'h0000_3000 + 32'(4 * i));
            chk("stream_pc8", f_pc8, 32'h0000_3008 + 32'(4 * i));
        end

        // Stall with 1-wait memory: head frozen, fetch stops with two entries.
        mem_wait = 1;
        do_reset();
        wait_head("stall_head", 32'h0000_3004);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_frozen", f_pc, 32'h0000_3004);
        end
        chk("stall_noreq", 32'(im_req), 32'd0);
        stall = 1'b0;
        pop_next("stall_rel0", 32'h0000_3004);
        pop_next("stall_rel1", 32'h0000_3008);
        pop_next("stall_rel2", 32'h0000_300C);

        // Redirect with head 0x3008 and 0x300C queued behind it.
        mem_wait = 0;
        do_reset();
        wait_head("fill_head", 32'h0000_3008);
        stall = 1'b1;
        step();
        step();
        chk("fill_noreq", 32'(im_req), 32'd0);
        stall = 1'b0;
        do_redirect(32'h0000_3100);
        pop_next("redir_full", 32'h0000_3100);

        // Redirect with empty queue and the delay slot still in flight.
        mem_wait = 3;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            if (im_req && im_addr == 32'h0000_3010 && !f_valid) break;
            step();
        end
        chk("inflight_addr", im_addr, 32'h0000_3010);
        do_redirect(32'h0000_3200);
        pop_next("inflight_slot", 32'h0000_3010);
        pop_next("inflight_tgt", 32'h0000_3200);

        // Redirect while a younger request is in flight: its data must be dropped.
        mem_wait = 2;
        for (int i = 0; i < 80; i++) begin
            if (f_valid && im_req) break;
            step();
        end
        do_redirect(32'h0000_3300);
        pop_next("squash_tgt", 32'h0000_3300);

        // 32-bit wrap of the fetch PC.
        mem_wait = 0;
        wait_valid();
        do_redirect(32'hFFFF_FFF8);
        pop_next("wrap0", 32'hFFFF_FFF8);
        pop_next("wrap1", 32'hFFFF_FFFC);
        pop_next("wrap2", 32'h0000_0000);

`ifdef PC_FETCH_SEQ_ALIGN_CHECK_EN
        wait_valid();
        do_redirect(32'h0000_3102);
        wait_head("adel_pc", 32'h0000_3102);
        stall = 1'b1;
        chk("adel_flag", 32'(f_adel), 32'd1);
        chk("adel_instr", f_instr, 32'h0);
        step();
        step();
        chk("adel_noreq", 32'(im_req), 32'd0);
        stall = 1'b0;
        do_redirect(32'h0000_4180);
        pop_next("adel_resume", 32'h0000_4180);
`endif

        // Reset with a request in flight; a late ready afterwards must be ignored.
        mem_wait = 3;
        for (int i = 0; i < 20; i++) begin
            if (im_req) break;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_req", 32'(im_req), 32'd0);
        chk("rst2_valid", 32'(f_valid), 32'd0);
        force_ready = 1'b1;
        step();
        force_ready = 1'b0;
        chk("late_ready_valid", 32'(f_valid), 32'd0);
        chk("late_ready_req", 32'(im_req), 32'd1);
        chk("late_ready_addr", im_addr, 32'h0000_3000);

        // Random stalls, wait states and legal redirects.
        mem_rand = 1'b1;
        do_reset();
        start = pops;
        for (int i = 0; i < 3000; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            if (!wait_tgt && $urandom_range(0, 7) == 0) begin
                r = $urandom();
                redirect    = 1'b1;
                redirect_pc = ($urandom_range(0, 15) == 0) ? ((r | 32'hFFFF_FF00) & 32'hFFFF_FFFC)
                                                            : (r & 32'hFFFF_FFFC);
            end else begin
                redirect = 1'b0;
            end
            step();
        end
        redirect = 1'b0;
        stall    = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("rand_progress", 32'((pops - start) > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
